// File: rtl/relay_alu_pkg.sv
// Shared types for the relay-timed ALU: function codes, FSM states and
// the settle-counter width.
package relay_alu_pkg;

   typedef enum logic [2:0] {
      FN_ADD = 3'b000,
      FN_INC = 3'b001,
      FN_AND = 3'b010,
      FN_OR  = 3'b011,
      FN_XOR = 3'b100,
      FN_NOT = 3'b101,
      FN_SHL = 3'b110,
      FN_CLR = 3'b111
   } fn_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // SETTLE is at most 15, so SETTLE-1 always fits in four bits
   localparam int CNT_W = 4;

   // slice select: 00 AND, 01 OR, 10 XOR, 11 NOT
   typedef logic [1:0] slice_sel_t;

endpackage

// File: rtl/relay_logic_slice.sv
// One bit of the bitwise function path: AND / OR / XOR / NOT-b.
module relay_logic_slice
   import relay_alu_pkg::*;
(
   input  logic       b,
   input  logic       c,
   input  slice_sel_t sel,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      unique case (sel)
         2'b00: y = b & c;
         2'b01: y = b | c;
         2'b10: y = b ^ c;
         2'b11: y = ~b;
      endcase
   end

endmodule

// File: rtl/relay_logic_unit.sv
// Relay-timed ALU: captures operands on start, waits SETTLE cycles, then
// registers result and flags and pulses done for one cycle.
module relay_logic_unit
   import relay_alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       fn,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             sign
);

   state_e             state_q, state_d;
   fn_e                fn_q;
   logic [WIDTH-1:0]   b_q, c_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH:0]     sum_add, sum_inc;
   logic [WIDTH-1:0]   logic_y;
   slice_sel_t         slice_sel;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic               capture, finish;

   assign capture = (state_q == ST_IDLE) && start;
   assign finish  = (state_q == ST_SETTLE) && (cnt_q == '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start)  state_d = ST_SETTLE;
         ST_SETTLE: if (finish) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   assign ready = (state_q == ST_IDLE);
   assign done  = (state_q == ST_DONE);

   // ---------------- bitwise path ----------------
   always_comb begin
      slice_sel = 2'b00;
      unique case (fn_q)
         FN_OR:   slice_sel = 2'b01;
         FN_XOR:  slice_sel = 2'b10;
         FN_NOT:  slice_sel = 2'b11;
         default: slice_sel = 2'b00;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      relay_logic_slice u_slice (
         .b   (b_q[i]),
         .c   (c_q[i]),
         .sel (slice_sel),
         .y   (logic_y[i])
      );
   end

   // ---------------- arithmetic / rotate / result mux ----------------
   assign sum_add = {1'b0, b_q} + {1'b0, c_q};
   assign sum_inc = {1'b0, b_q} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      unique case (fn_q)
         FN_ADD: {carry_d, res_d} = sum_add;
         FN_INC: {carry_d, res_d} = sum_inc;
         FN_AND,
         FN_OR,
         FN_XOR,
         FN_NOT: res_d = logic_y;
         FN_SHL: begin
            res_d   = {b_q[WIDTH-2:0], b_q[WIDTH-1]};
            carry_d = b_q[WIDTH-1];
         end
         FN_CLR: res_d = '0;
      endcase
   end

   // ---------------- operand capture, counter, output registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fn_q   <= FN_ADD;
         b_q    <= '0;
         c_q    <= '0;
         cnt_q  <= '0;
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b1;
         sign   <= 1'b0;
      end else begin
         if (capture) begin
            fn_q  <= fn_e'(fn);
            b_q   <= b;
            c_q   <= c;
            cnt_q <= CNT_W'(SETTLE - 1);
         end else if (state_q == ST_SETTLE && !finish) begin
            cnt_q <= cnt_q - 1'b1;
         end
         // outputs move only on the edge entering DONE
         if (finish) begin
            result <= res_d;
            carry  <= carry_d;
            zero   <= (res_d == '0);
            sign   <= res_d[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_relay_logic_unit.sv
// Directed bench for relay_logic_unit at WIDTH=8, SETTLE=4.
module tb_relay_logic_unit;

   localparam int WIDTH  = 8;
   localparam int SETTLE = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [2:0]       fn;
   logic [WIDTH-1:0] b, c;
   logic             ready, done;
   logic [WIDTH-1:0] result;
   logic             carry, zero, sign;

   int n_cmp = 0;
   int n_err = 0;

   relay_logic_unit #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .fn     (fn),
      .b      (b),
      .c      (c),
      .ready  (ready),
      .done   (done),
      .result (result),
      .carry  (carry),
      .zero   (zero),
      .sign   (sign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // launch an op at edge k, check done timing, then result and flags
   task automatic do_op(input string tag, input logic [2:0] f,
                        input logic [7:0] bv, input logic [7:0] cv,
                        input logic [7:0] er, input logic ec,
                        input logic ez, input logic es);
      @(negedge clk);
      start = 1'b1; fn = f; b = bv; c = cv;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 32'(ready), 32'd0);
      for (int i = 1; i <= SETTLE; i++) begin
         tick();
         if (i < SETTLE) begin
            if (done !== 1'b0) chk({tag, "_early_done"}, 32'(done), 32'd0);
         end else begin
            chk({tag, "_done"}, 32'(done), 32'd1);
         end
      end
      chk({tag, "_res"},   32'(result), 32'(er));
      chk({tag, "_carry"}, 32'(carry),  32'(ec));
      chk({tag, "_zero"},  32'(zero),   32'(ez));
      chk({tag, "_sign"},  32'(sign),   32'(es));
      tick();
      chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
      chk({tag, "_done_off"}, 32'(done), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      reset = 1'b1; start = 1'b0; fn = 3'b000; b = '0; c = '0;
      #12;
      chk("rst_res",   32'(result), 32'h0);
      chk("rst_carry", 32'(carry),  32'h0);
      chk("rst_zero",  32'(zero),   32'h1);
      chk("rst_sign",  32'(sign),   32'h0);
      chk("rst_done",  32'(done),   32'h0);
      chk("rst_ready", 32'(ready),  32'h1);
      @(negedge clk);
      reset = 1'b0;

      do_op("add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
      do_op("add",      3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
      do_op("and",      3'b010, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0);
      do_op("or",       3'b011, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 1'b1);
      do_op("xor",      3'b100, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0, 1'b1);
      do_op("not",      3'b101, 8'hC3, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
      do_op("shl",      3'b110, 8'h81, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
      do_op("inc",      3'b001, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
      do_op("clr",      3'b111, 8'hAB, 8'hCD, 8'h00, 1'b0, 1'b1, 1'b0);

      // busy: second start and operand change while not ready are ignored
      @(negedge clk);
      start = 1'b1; fn = 3'b000; b = 8'h01; c = 8'h02;
      tick();
      dones = 0;
      @(negedge clk);
      fn = 3'b111; b = 8'hAA;
      tick();
      if (done) dones++;
      tick();
      if (done) dones++;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) dones++;
      end
      chk("busy_dones", 32'(dones), 32'd1);
      chk("busy_res",   32'(result), 32'h03);

      // reset mid-settle
      @(negedge clk);
      start = 1'b1; fn = 3'b000; b = 8'h05; c = 8'h06;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_res",   32'(result), 32'h0);
      chk("mid_rst_zero",  32'(zero),   32'h1);
      chk("mid_rst_done",  32'(done),   32'h0);
      chk("mid_rst_ready", 32'(ready),  32'h1);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) dones++;
      end
      chk("mid_rst_nodone", 32'(dones), 32'd0);
      do_op("post_rst_inc", 3'b001, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
